bluetooth_tx: RTL and testbench
===============================

Name: bluetooth_tx

Overview:
UART transmitter for the Bluetooth serial link: the outbound counterpart of the existing `bluetooth` receiver. It accepts bytes from game logic (score, status codes, echo of commands) into a small FIFO. It serialises them 8N1, LSB first, on `tx`, which drives the HC-05/06 module RXD pin. Bit timing matches the receiver, so a tx→get loopback reproduces the byte on the receiver's `data`.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per serial bit (100 MHz / 9600 baud); benches use 14.
FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, ≥2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
data_in  input  8  byte to transmit.
wr_en  input  1  write strobe; `data_in` is pushed on the rising edge where `wr_en`=1 and `full`=0.
full  output  1  FIFO holds FIFO_DEPTH bytes; writes are ignored.
tx  output  1  serial line, idle high; registered.
busy  output  1  1 when the FIFO is non-empty or a frame is in progress.

Behaviour:
- One clock domain. Reset is synchronous and active-high, and overrides everything on the same edge.
- Reset values: `tx`=1, `busy`=0, `full`=0, FIFO empty (pointers and count 0), state IDLE, bit counter 0, baud counter 0.
- FIFO:
  - Circular buffer with `wr_ptr`, `rd_ptr` and a count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - A write with `full`=1 is dropped silently, even if a pop happens on the same edge.
  - A write and a pop on the same edge leave the count unchanged.
  - `full` = (count == FIFO_DEPTH), combinational from the registered count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop the head into the 8-bit shift register, clear the baud counter, go to START.
  - START: `tx`=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the final cycle:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle bit);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at the terminal count. Counter width is clog2(CLKS_PER_BIT).
- Latency: when a write is accepted on edge N with the FSM idle and the FIFO empty, `tx` goes low after edge N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles, from the start-bit falling edge to the end of the stop bit.
- `busy` = (state != IDLE) | (count != 0). It is 0 only when the line is idle and there is nothing queued.
- The byte is captured at pop. Later writes never alter a frame already in flight.
- Reset mid-frame: `tx`=1 on the next edge and queued bytes are discarded. No partial-frame completion.
- `tx` is glitch-free: driven from a flop, never from combinational logic.

Test Plan:
1. Reset then idle (CLKS_PER_BIT=14): hold `rst`=1 for 3 cycles, then 50 idle cycles → `tx`=1, `busy`=0, `full`=0 throughout.
2. Single byte 0x41 ('A'): one-cycle `wr_en` → `tx` low on the following edge. Line sequence, each level 14 cycles: 0,1,0,0,0,0,0,1,0,1. `busy` drops after 140 cycles.
3. Loopback: `bluetooth_tx.tx` drives `bluetooth.get`; send 0x41, then 0x0F → receiver `data` shows 0x41, then 0x0F.
4. FIFO fill and overflow: write 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles. `full` asserts once four bytes are queued, i.e. while 0x11 is in flight with 0x22–0x55 queued. 0x11–0x55 are transmitted back-to-back with no idle gap between stop and start (50×14 cycles). Any write attempted while `full`=1 (e.g. 0x66) is dropped and never appears on `tx`.
5. Simultaneous write and pop: time a write to coincide with the STOP→START pop edge while count=1 → count stays 1, and both bytes are transmitted in order.
6. Reset mid-frame: assert `rst` during DATA bit 3 of 0xA5, with 0x5A queued → `tx`=1 and `busy`=0 after that edge. No further frames; 0x5A is never sent.

Source files
------------

// File: rtl/bluetooth_tx.sv
// bluetooth_tx: 8N1 UART transmitter, LSB first, idle-high line, fed by a small byte FIFO.
// Frames follow each other back-to-back while the FIFO holds data.
module bluetooth_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       tx,
    output logic       busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [7:0]      shift, shift_n;
    logic [2:0]      idx, idx_n;
    logic [BW-1:0]   baud, baud_n;
    logic            baud_end, push, pop, tx_d;

    assign full     = count == DEPTH;
    assign busy     = (state != IDLE) || (count != '0);
    assign baud_end = baud == BAUD_MAX;
    assign push     = wr_en && !full;
    // A pop loads the shifter either from idle or on the last stop-bit cycle.
    assign pop      = (count != '0) && (state == IDLE || (state == STOP && baud_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shift  <= '0;
            idx    <= '0;
            baud   <= '0;
            tx     <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            shift  <= shift_n;
            idx    <= idx_n;
            baud   <= baud_n;
            tx     <= tx_d;
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        baud_n  = (state == IDLE || baud_end) ? '0 : baud + BW'(1);
        if (pop) begin
            state_n = START;
            shift_n = mem[rd_ptr];
            baud_n  = '0;
        end else if (baud_end) begin
            case (state)
                START: begin
                    state_n = DATA;
                    idx_n   = '0;
                end
                DATA: begin
                    shift_n = shift >> 1;
                    idx_n   = idx + 3'd1;
                    state_n = (idx == 3'd7) ? STOP : DATA;
                end
                STOP:    state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end

    // Line level is computed from the next state so the registered tx lines up with it.
    always_comb begin
        tx_d = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
    end
endmodule

// File: tb/tb_bluetooth_tx.sv
// tb_bluetooth_tx: table-driven frame checks plus a line-decoding scoreboard for bluetooth_tx.
module tb_bluetooth_tx;
    localparam int CPB = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic       full, tx, busy;

    bluetooth_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en),
        .full(full), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;
    int         frames = 0;
    int         rst_cnt = 0;
    int         bad, bad2, bad3, cyc;

    always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        data_in = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        if (busy) n = -1;
    endtask

    // Scoreboard: decode every frame at mid-bit and compare with the queued byte.
    logic [7:0] rx;
    logic       sbit, pbit;
    int         r0;
    initial begin
        forever begin
            @(negedge tx);
            r0 = rst_cnt;
            repeat (CPB / 2) @(posedge clk);
            #1 sbit = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 rx[i] = tx;
            end
            repeat (CPB) @(posedge clk);
            #1 pbit = tx;
            if (rst_cnt == r0) begin
                frames++;
                check("start_bit", int'(sbit), 0);
                check("stop_bit", int'(pbit), 1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got %02h, expected no frame", rx);
                end else begin
                    check("sb_byte", int'(rx), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        vecs[0] = '{8'h41, 10'b1010000010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'hA5, 10'b1101001010};
        vecs[4] = '{8'h80, 10'b1100000000};

        // Reset then idle
        repeat (3) step();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_full", int'(full), 0);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) bad++;
        end
        check("idle_50_bad_cycles", bad, 0);

        // Single-byte frames, line checked every cycle against the table
        foreach (vecs[v]) begin
            exp_q.push_back(vecs[v].data);
            wr(vecs[v].data);
            check($sformatf("v%0d_tx_before_start", v), int'(tx), 1);
            check($sformatf("v%0d_busy_queued", v), int'(busy), 1);
            for (int b = 0; b < 10; b++) begin
                bad = 0;
                for (int c = 0; c < CPB; c++) begin
                    step();
                    if (tx !== vecs[v].frame[b]) bad++;
                end
                check($sformatf("v%0d_bit%0d_bad_cycles", v, b), bad, 0);
            end
            check($sformatf("v%0d_busy_last", v), int'(busy), 1);
            step();
            check($sformatf("v%0d_busy_drop", v), int'(busy), 0);
            repeat (3) step();
        end

        // Loopback-style pair, second byte queued behind the first
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h0F);
        wr(8'h41);
        wr(8'h0F);
        wait_idle(cyc);
        check("pair_idle_cycles", cyc, 280);
        repeat (3) step();

        // FIFO fill and overflow
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'((i + 1) * 8'h11));
            wr(8'((i + 1) * 8'h11));
            check($sformatf("fill_full_%0d", i), int'(full), (i >= 4) ? 1 : 0);
        end
        wait_idle(cyc);
        check("fill_idle_cycles", cyc, 696);
        repeat (3) step();

        // Write coinciding with the STOP->START pop
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h96);
        wr(8'h3C);
        wr(8'hC3);
        repeat (139) step();
        check("simul_tx_stop", int'(tx), 1);
        wr(8'h96);
        check("simul_tx_start", int'(tx), 0);
        check("simul_full", int'(full), 0);
        check("simul_busy", int'(busy), 1);
        wait_idle(cyc);
        check("simul_idle_cycles", cyc, 280);
        repeat (3) step();

        // Reset during DATA bit 3 of 0xA5 with 0x5A queued
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        wr(8'hA5);
        wr(8'h5A);
        repeat (59) step();
        check("midrst_tx_bit3", int'(tx), 0);
        check("midrst_busy_pre", int'(busy), 1);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_full", int'(full), 0);
        bad = 0;
        bad2 = 0;
        bad3 = 0;
        repeat (300) begin
            step();
            if (tx !== 1'b1) bad++;
            if (busy !== 1'b0) bad2++;
            if (full !== 1'b0) bad3++;
        end
        check("midrst_tx_bad_cycles", bad, 0);
        check("midrst_busy_bad_cycles", bad2, 0);
        check("midrst_full_bad_cycles", bad3, 0);

        check("sb_frames", frames, 15);
        check("sb_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
